// File: rtl/phase_dac_serializer.sv
// phase_dac_serializer: converts a 32-bit phase sample to a 16-bit DAC code and shifts it out MSB first over SPI
// Optional feature macro: PHASE_DAC_SAT_EN (clamp to 16-bit signed range and report saturation on o_sat)
module phase_dac_serializer #(
    parameter int CLK_DIV    = 2,
    parameter bit OFFSET_BIN = 1'b1
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_update,
    input  logic signed [31:0] i_data,
    output logic               o_dac_sclk,
    output logic               o_dac_cs_n,
    output logic               o_dac_sdi,
    output logic               o_busy,
    output logic [15:0]        o_code,
    output logic               o_sat,
    output logic               o_overrun
);
    typedef enum logic [1:0] {IDLE = 2'b00, SHIFT = 2'b01, HOLD = 2'b10} state_t;
    localparam logic [7:0] DIV    = 8'(CLK_DIV);
    localparam logic [7:0] DIV_M1 = 8'(CLK_DIV - 1);
    state_t      state, state_next;
    logic [7:0]  cnt;
    logic [4:0]  half;
    logic [15:0] sr, v, conv_code, pend_code, load_code;
    logic        conv_sat, pend_sat, pend_valid, load_sat;
    logic        div_end, last_half, start, consume, load, store;
    // reduce the 32-bit sample to a 16-bit value and map it to the DAC code format
    always_comb begin
`ifdef PHASE_DAC_SAT_EN
        conv_sat = (i_data > 32'sd32767) || (i_data < -32'sd32768);
        v = (i_data > 32'sd32767) ? 16'h7fff : (i_data < -32'sd32768) ? 16'h8000 : i_data[15:0];
`else
        conv_sat = 1'b0;
        v = i_data[15:0];
`endif
        conv_code = OFFSET_BIN ? {~v[15], v[14:0]} : v;
    end
    assign div_end   = (state == SHIFT) && (cnt == DIV_M1);
    assign last_half = (half == 5'd31);
    assign start     = (state == IDLE) && i_update;
    assign consume   = (state == HOLD) && (cnt == DIV);
    assign load      = start || consume;
    assign store     = i_update && (state != IDLE);
    assign load_code = start ? conv_code : pend_code;
    assign load_sat  = start ? conv_sat : pend_sat;
    // state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_next;
    end
    // next state: HOLD is stretched by one cycle when another frame is queued so CS stays high CLK_DIV+1 cycles
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = i_update ? SHIFT : IDLE;
            SHIFT:   state_next = (div_end && last_half) ? HOLD : SHIFT;
            HOLD:    state_next = consume ? SHIFT :
                                  ((cnt == DIV_M1) && !(pend_valid || i_update)) ? IDLE : HOLD;
            default: state_next = IDLE;
        endcase
    end
    // outputs decoded from state; SDI is forced low outside a frame
    always_comb begin
        o_busy     = (state != IDLE);
        o_dac_cs_n = (state != SHIFT);
        o_dac_sdi  = (state == SHIFT) && sr[15];
    end
    // timing counters, serial clock, shift register and one-deep pending buffer
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt        <= '0;
            half       <= '0;
            o_dac_sclk <= 1'b0;
            sr         <= '0;
            o_code     <= '0;
            o_sat      <= 1'b0;
            o_overrun  <= 1'b0;
            pend_valid <= 1'b0;
            pend_code  <= '0;
            pend_sat   <= 1'b0;
        end else begin
            cnt        <= (state_next != state || div_end || state == IDLE) ? 8'd0 : cnt + 8'd1;
            half       <= (state != SHIFT || state_next != SHIFT) ? 5'd0 : half + 5'(div_end);
            o_dac_sclk <= (state_next == SHIFT) && (o_dac_sclk ^ div_end);
            sr         <= load ? load_code : (div_end && o_dac_sclk && !last_half) ? {sr[14:0], 1'b0} : sr;
            o_code     <= load ? load_code : o_code;
            o_sat      <= load && load_sat;
            o_overrun  <= store && pend_valid && !consume;
            pend_valid <= store || (pend_valid && !consume);
            pend_code  <= store ? conv_code : pend_code;
            pend_sat   <= store ? conv_sat : pend_sat;
        end
    end
endmodule

// File: tb/tb_phase_dac_serializer.sv
// tb_phase_dac_serializer: scoreboard bench for phase_dac_serializer (CLK_DIV=2, OFFSET_BIN=1); honours PHASE_DAC_SAT_EN
module tb_phase_dac_serializer;
    typedef struct packed {logic [15:0] code; logic sat;} exp_t;
`ifdef PHASE_DAC_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif
    logic clk = 1'b0, rst_n = 1'b0, update = 1'b0;
    logic signed [31:0] data = '0;
    logic sclk, cs_n, sdi, busy, sat, overrun;
    logic [15:0] code;
    int checks = 0, errors = 0;
    exp_t q[$];
    exp_t cur;
    bit in_frame = 0;
    int nbits = 0, low_cnt = 0, sat_cnt = 0, hi_cnt = 0, last_hi = 0, frames = 0, ovr_cnt = 0;
    logic [15:0] shv = '0;
    logic prev_cs = 1'b1, prev_sclk = 1'b0;

    phase_dac_serializer #(.CLK_DIV(2), .OFFSET_BIN(1'b1)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_update(update), .i_data(data),
        .o_dac_sclk(sclk), .o_dac_cs_n(cs_n), .o_dac_sdi(sdi), .o_busy(busy),
        .o_code(code), .o_sat(sat), .o_overrun(overrun));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [15:0] c, input logic s);
        q.push_back('{code: c, sat: s});
    endtask

    task automatic upd(input logic signed [31:0] d, input int pre);
        repeat (pre) @(posedge clk);
        #1 update = 1'b1; data = d;
        @(posedge clk);
        #1 update = 1'b0;
    endtask

    task automatic wait_frames(input int n, input int budget);
        int k = 0;
        while (frames < n && k < budget) begin
            @(negedge clk); #1; k++;
        end
        chk("frame_timeout", frames >= n, 1);
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (busy && k < budget) begin
            @(negedge clk); #1; k++;
        end
        chk("idle_timeout", busy, 0);
    endtask

    // monitor: reassemble each SPI frame on SCLK rising edges and compare with the scoreboard
    always @(negedge clk) begin
        if (overrun) ovr_cnt++;
        if (!rst_n) begin
            in_frame = 0; prev_cs = 1'b1; prev_sclk = 1'b0; hi_cnt = 0;
        end else begin
            if (prev_cs && !cs_n) begin
                last_hi = hi_cnt; in_frame = 1; nbits = 0; low_cnt = 0; sat_cnt = 0; shv = '0;
                chk("frame_expected", q.size() > 0, 1);
                cur = (q.size() > 0) ? q.pop_front() : '0;
                chk("o_code", code, cur.code);
            end
            if (in_frame) begin
                if (!cs_n) low_cnt++;
                if (sclk && !prev_sclk) begin shv = {shv[14:0], sdi}; nbits++; end
                if (sat) sat_cnt++;
            end
            if (!prev_cs && cs_n && in_frame) begin
                chk("sclk_rises", nbits, 16);
                chk("sdi_word", shv, cur.code);
                chk("cs_low_len", low_cnt, 64);
                chk("sat_pulses", sat_cnt, cur.sat);
                in_frame = 0;
                frames++;
            end
            hi_cnt = cs_n ? (prev_cs ? hi_cnt + 1 : 1) : 0;
            prev_cs = cs_n; prev_sclk = sclk;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int f, o, n;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cs_n", cs_n, 1); chk("rst_sclk", sclk, 0); chk("rst_sdi", sdi, 0);
        chk("rst_busy", busy, 0); chk("rst_code", code, 0); chk("rst_sat", sat, 0);
        chk("rst_overrun", overrun, 0);
        rst_n = 1'b1;
        // zero sample: 0x8000, HOLD of two cycles then idle
        f = frames; push(16'h8000, 1'b0); upd(0, 1);
        wait_frames(f + 1, 200);
        n = 0;
        while (busy && n < 10) begin n++; @(negedge clk); #1; end
        chk("hold_len", n, 2);
        // out-of-range samples: clamp or wrap depending on build
        f = frames; push(SAT ? 16'hffff : 16'h1c40, SAT); upd(40000, 1); wait_frames(f + 1, 200); wait_idle(20);
        f = frames; push(SAT ? 16'h0000 : 16'he3c0, SAT); upd(-40000, 1); wait_frames(f + 1, 200); wait_idle(20);
        f = frames; push(SAT ? 16'hffff : 16'h0000, SAT); upd(32768, 1); wait_frames(f + 1, 200); wait_idle(20);
        // three updates in one frame: one overrun, last sample wins
        f = frames; o = ovr_cnt;
        push(16'h8001, 1'b0); upd(1, 1);
        upd(2, 5);
        push(16'h8003, 1'b0); upd(3, 3);
        wait_frames(f + 2, 400); wait_idle(20);
        chk("overrun_count", ovr_cnt - o, 1);
        // update on the cycle HOLD ends: back-to-back frame, CS high CLK_DIV+1 cycles
        f = frames; o = ovr_cnt;
        push(16'h9234, 1'b0); upd(32'h1234, 1);
        wait_frames(f + 1, 200);
        push(16'h7fff, 1'b0); upd(-1, 1);
        wait_frames(f + 2, 200);
        chk("cs_high_gap", last_hi, 3);
        wait_idle(20);
        chk("no_overrun_b2b", ovr_cnt - o, 0);
        // update on the consumption cycle refills the buffer without overrun
        f = frames; o = ovr_cnt;
        push(16'h8100, 1'b0); upd(32'h100, 1);
        push(16'h8200, 1'b0); upd(32'h200, 10);
        wait_frames(f + 1, 200);
        push(16'h8300, 1'b0); upd(32'h300, 2);
        wait_frames(f + 3, 400); wait_idle(20);
        chk("no_overrun_consume", ovr_cnt - o, 0);
        // reset at bit 7 aborts the frame; next update sends a full frame
        push(16'hd555, 1'b0); upd(32'h5555, 1);
        n = 0;
        while (!(in_frame && nbits == 7) && n < 200) begin @(negedge clk); #1; n++; end
        chk("reach_bit7", nbits, 7);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_cs_n", cs_n, 1); chk("abort_sclk", sclk, 0); chk("abort_sdi", sdi, 0);
        chk("abort_busy", busy, 0); chk("abort_code", code, 0);
        n = 0;
        repeat (10) begin @(negedge clk); n += sclk; end
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (10) begin @(negedge clk); n += sclk; end
        chk("abort_no_sclk", n, 0);
        f = frames; push(SAT ? 16'hffff : 16'h2aaa, SAT); upd(32'haaaa, 1);
        wait_frames(f + 1, 200); wait_idle(20);
        chk("queue_empty", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
